// File: rtl/sa_pkg.sv
// Shared types and defaults for the serial-adder receive side.
package sa_pkg;

  localparam int unsigned SA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } state_e;

endpackage

// File: rtl/sa_collect_if.sv
// Serial-in / parallel-out link between the bit-serial adder, sa_collect and the word consumer.
interface sa_collect_if #(
  parameter int unsigned W = sa_pkg::SA_W_DEFAULT
) ();

  logic         start;
  logic         bit_valid;
  logic         sum_in;
  logic         co_in;
  logic         res_ready;
  logic [W:0]   result;
  logic         res_valid;
  logic         busy;
  logic         err_overrun;

  modport master (
    output start, bit_valid, sum_in, co_in, res_ready,
    input  result, res_valid, busy, err_overrun
  );

  modport slave (
    input  start, bit_valid, sum_in, co_in, res_ready,
    output result, res_valid, busy, err_overrun
  );

endinterface

// File: rtl/sa_shift_in.sv
// W-bit right-shift register, LSB-first input; clear has priority over shift.
module sa_shift_in #(
  parameter int unsigned W = sa_pkg::SA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q_shift
);

  logic [W-1:0] q_q;

  // Value the register takes on an enabled shift; the collector captures it on the last bit.
  assign q_shift = {din, q_q[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_shift;
    end
  end

endmodule

// File: rtl/sa_collect.sv
// Reassembles an LSB-first serial sum plus final carry into a parallel word with valid/ready.
module sa_collect
  import sa_pkg::*;
#(
  parameter int unsigned W = SA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  sa_collect_if.slave  bus
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W:0]     result_q, result_d;
  logic           res_valid_q, res_valid_d;
  logic           err_q, err_d;
  logic           sh_clr, sh_en;
  logic [W-1:0]   sh_next;

  sa_shift_in #(.W(W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .en      (sh_en),
    .din     (bus.sum_in),
    .q_shift (sh_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.start) state_d = SHIFT;
      SHIFT: if (!bus.start && bus.bit_valid && cnt_q == LastCnt) state_d = FULL;
      FULL:  if (bus.res_ready) state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_clr      = 1'b0;
    sh_en       = 1'b0;
    cnt_d       = cnt_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_clr = 1'b1;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        // A restart drops any bit presented in the same cycle.
        if (bus.start) begin
          sh_clr = 1'b1;
          cnt_d  = '0;
        end else if (bus.bit_valid) begin
          sh_en = 1'b1;
          if (cnt_q == LastCnt) begin
            cnt_d       = '0;
            result_d    = {bus.co_in, sh_next};
            res_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      FULL: begin
        if (bus.bit_valid) err_d = 1'b1;
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (bus.start) begin
            sh_clr = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.result      = result_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_sa_collect.sv
// Bench for sa_collect: word-level reference model checked every cycle, plus literal checkpoints.
module tb_sa_collect;
  import sa_pkg::*;

  localparam int unsigned W = SA_W_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_collect_if #(.W(W)) bus ();

  sa_collect #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Word-level view: are we gathering bits, holding a finished word, and what is its value.
  typedef struct {
    bit gathering;
    bit holding;
    bit valid;
    bit err;
    int nbits;
    int acc;
    int res;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, bit r, bit st, bit bv, bit si, bit co, bit rr);
    model_t x;
    x = s;
    if (r) begin
      x.gathering = 0; x.holding = 0; x.valid = 0; x.err = 0;
      x.nbits = 0; x.acc = 0; x.res = 0;
      return x;
    end
    if (s.holding) begin
      if (bv) x.err = 1;
      if (rr) begin
        x.holding = 0;
        x.valid   = 0;
        if (st) begin x.gathering = 1; x.nbits = 0; x.acc = 0; end
      end
    end else if (s.gathering) begin
      if (st) begin
        x.nbits = 0; x.acc = 0;
      end else if (bv) begin
        x.acc = s.acc + (int'(si) << s.nbits);
        if (s.nbits == int'(W) - 1) begin
          x.res = x.acc + (int'(co) << W);
          x.valid = 1; x.holding = 1; x.gathering = 0; x.nbits = 0;
        end else begin
          x.nbits = s.nbits + 1;
        end
      end
    end else if (st) begin
      x.gathering = 1; x.nbits = 0; x.acc = 0;
    end
    return x;
  endfunction

  always @(posedge clk)
    m <= step(m, rst, bus.start, bus.bit_valid, bus.sum_in, bus.co_in, bus.res_ready);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_result", bus.result, m.res);
      check("cyc_res_valid", bus.res_valid, m.valid);
      check("cyc_busy", bus.busy, m.gathering | m.holding);
      check("cyc_err_overrun", bus.err_overrun, m.err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W:0] r, input bit v, input bit b,
                            input bit e);
    check({tag, "_result"}, bus.result, r);
    check({tag, "_res_valid"}, bus.res_valid, v);
    check({tag, "_busy"}, bus.busy, b);
    check({tag, "_err"}, bus.err_overrun, e);
  endtask

  task automatic open_word();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // Non-final bits carry the inverse carry so a carry sampled too early is visible.
  task automatic send_word(input logic [W-1:0] bits, input bit co, input int gap);
    for (int i = 0; i < int'(W); i++) begin
      bus.bit_valid = 1'b1;
      bus.sum_in    = bits[i];
      bus.co_in     = (i == int'(W) - 1) ? co : ~co;
      tick();
      bus.bit_valid = 1'b0;
      if (i < int'(W) - 1) repeat (gap) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.sum_in = 1'b0;
    bus.co_in = 1'b0; bus.res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    expect_out("reset", 5'b00000, 0, 0, 0);

    // 5+3
    open_word();
    send_word(4'b1000, 1'b0, 0);
    expect_out("w5p3", 5'b01000, 1, 1, 0);
    consume();
    expect_out("w5p3_ack", 5'b01000, 0, 0, 0);

    // 15+1
    open_word();
    send_word(4'b0000, 1'b1, 0);
    expect_out("w15p1", 5'b10000, 1, 1, 0);
    consume();

    // 7+7 with one idle cycle between bits
    open_word();
    send_word(4'b1110, 1'b0, 1);
    expect_out("w7p7_gaps", 5'b01110, 1, 1, 0);
    consume();

    // Backpressure and overrun, then back-to-back restart
    open_word();
    send_word(4'b0011, 1'b0, 0);
    repeat (5) tick();
    expect_out("bp_hold", 5'b00011, 1, 1, 0);
    bus.bit_valid = 1'b1; bus.sum_in = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    expect_out("overrun", 5'b00011, 1, 1, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("start_no_ready", 5'b00011, 1, 1, 1);
    bus.start = 1'b1; bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0; bus.res_ready = 1'b0;
    expect_out("b2b", 5'b00011, 0, 1, 1);
    send_word(4'b1001, 1'b1, 0);
    expect_out("b2b_word", 5'b11001, 1, 1, 1);
    consume();

    // Restart after two bits, including a bit presented with the restart
    open_word();
    send_word(4'b0011, 1'b0, 0);
    consume();
    open_word();
    bus.bit_valid = 1'b1; bus.sum_in = 1'b1;
    tick(); tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.bit_valid = 1'b0;
    send_word(4'b0101, 1'b0, 0);
    expect_out("restart", 5'b00101, 1, 1, 1);
    consume();

    // Reset mid-word, then bit_valid in IDLE
    open_word();
    bus.bit_valid = 1'b1; bus.sum_in = 1'b1;
    tick(); tick(); tick();
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_mid", 5'b00000, 0, 0, 0);
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    expect_out("idle_bv", 5'b00000, 0, 0, 0);

    // Reset while holding a word
    open_word();
    send_word(4'b1111, 1'b1, 0);
    expect_out("w_full", 5'b11111, 1, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rst_full", 5'b00000, 0, 0, 0);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
